// File: rtl/fifo_wr_framer.sv
// Write-domain packet framer: wraps a valid/ready byte stream into
// header / payload / byte-count / XOR-checksum frames for the dual-clock FIFO.
module fifo_wr_framer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_LEN    = 16,
    parameter logic [3:0]  HDR_TAG    = 4'hA
) (
    input  logic                  wr_clk,
    input  logic                  rst,
    input  logic                  src_valid,
    output logic                  src_ready,
    input  logic [DATA_WIDTH-1:0] src_data,
    input  logic                  src_last,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_data,
    output logic [15:0]           pkt_count,
    output logic                  trunc_err,
    output logic                  busy
);

    localparam int unsigned LEN_W = 8;
    localparam int unsigned SEQ_W = 4;
    localparam int unsigned CNT_W = 16;
    localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_TRL_CNT,
        S_TRL_CSUM,
        S_DROP
    } state_t;

    state_t                  state, state_n;
    logic [SEQ_W-1:0]        seq, seq_n;
    logic [LEN_W-1:0]        len, len_n;
    logic [DATA_WIDTH-1:0]   csum, csum_n;
    logic [CNT_W-1:0]        pkt_cnt_q, pkt_cnt_n;
    logic                    trunc_q, trunc_n;
    // Set when a packet was cut: the source still owes its tail bytes.
    logic                    drop_pend, drop_pend_n;

    // State and datapath registers
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            seq       <= '0;
            len       <= '0;
            csum      <= '0;
            pkt_cnt_q <= '0;
            trunc_q   <= 1'b0;
            drop_pend <= 1'b0;
        end else begin
            state     <= state_n;
            seq       <= seq_n;
            len       <= len_n;
            csum      <= csum_n;
            pkt_cnt_q <= pkt_cnt_n;
            trunc_q   <= trunc_n;
            drop_pend <= drop_pend_n;
        end
    end

    // Next-state, datapath update and FIFO/source handshake
    always_comb begin
        state_n     = state;
        seq_n       = seq;
        len_n       = len;
        csum_n      = csum;
        pkt_cnt_n   = pkt_cnt_q;
        trunc_n     = 1'b0;
        drop_pend_n = drop_pend;
        src_ready   = 1'b0;
        fifo_wr_en  = 1'b0;
        fifo_data   = '0;

        unique case (state)
            S_IDLE: begin
                if (src_valid) begin
                    state_n = S_HDR;
                end
            end
            S_HDR: begin
                fifo_wr_en = !fifo_full;
                fifo_data  = DATA_WIDTH'({HDR_TAG, seq});
                if (!fifo_full) begin
                    len_n   = '0;
                    csum_n  = '0;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                src_ready  = !fifo_full;
                fifo_wr_en = src_valid && !fifo_full;
                fifo_data  = src_data;
                if (src_valid && !fifo_full) begin
                    len_n  = len + LEN_W'(1);
                    csum_n = csum ^ src_data;
                    if (src_last) begin
                        state_n = S_TRL_CNT;
                    end else if (len == LEN_LAST) begin
                        trunc_n     = 1'b1;
                        drop_pend_n = 1'b1;
                        state_n     = S_TRL_CNT;
                    end
                end
            end
            S_TRL_CNT: begin
                fifo_wr_en = !fifo_full;
                fifo_data  = DATA_WIDTH'(len);
                if (!fifo_full) begin
                    state_n = S_TRL_CSUM;
                end
            end
            S_TRL_CSUM: begin
                fifo_wr_en = !fifo_full;
                fifo_data  = csum;
                if (!fifo_full) begin
                    seq_n       = seq + SEQ_W'(1);
                    pkt_cnt_n   = pkt_cnt_q + CNT_W'(1);
                    drop_pend_n = 1'b0;
                    state_n     = drop_pend ? S_DROP : S_IDLE;
                end
            end
            S_DROP: begin
                src_ready = 1'b1;
                if (src_valid && src_last) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign pkt_count = pkt_cnt_q;
    assign trunc_err = trunc_q;
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_fifo_wr_framer.sv
// Bench for fifo_wr_framer: packet-level model of the expected FIFO byte stream
// checked on every write, plus literal expectations for the directed scenarios.
module tb_fifo_wr_framer;

    localparam int unsigned MAX_LEN = 16;

    logic       wr_clk = 1'b0;
    logic       rst;
    logic       src_valid;
    logic       src_ready;
    logic [7:0] src_data;
    logic       src_last;
    logic       fifo_full;
    logic       fifo_wr_en;
    logic [7:0] fifo_data;
    logic [15:0] pkt_count;
    logic       trunc_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  act_log[$];
    logic [3:0]  m_seq;
    int unsigned m_pkts;
    int unsigned m_trunc;
    int unsigned trunc_seen;

    fifo_wr_framer #(.DATA_WIDTH(8), .MAX_LEN(MAX_LEN), .HDR_TAG(4'hA)) dut (
        .wr_clk     (wr_clk),
        .rst        (rst),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_data   (src_data),
        .src_last   (src_last),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_data  (fifo_data),
        .pkt_count  (pkt_count),
        .trunc_err  (trunc_err),
        .busy       (busy)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected frame of a packet as the source sends it
    task automatic model_pkt(input logic [7:0] b[$]);
        int unsigned n;
        logic [7:0]  x;
        n = (b.size() > MAX_LEN) ? MAX_LEN : b.size();
        x = 8'h00;
        exp_q.push_back({4'hA, m_seq});
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back(b[i]);
            x = x ^ b[i];
        end
        exp_q.push_back(8'(n));
        exp_q.push_back(x);
        m_seq = m_seq + 4'd1;
        m_pkts++;
        if (b.size() > MAX_LEN) m_trunc++;
    endtask

    // Compare every FIFO write against the model, away from the clock edge
    always begin
        @(negedge wr_clk);
        #2;
        if (!rst) begin
            if (trunc_err) trunc_seen++;
            if (fifo_full) begin
                chk("wr_en_while_full", 32'(fifo_wr_en), 32'd0);
                chk("ready_while_full", 32'(src_ready), 32'd0);
            end
            if (fifo_wr_en) begin
                act_log.push_back(fifo_data);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%0h required=none at %0t", fifo_data, $time);
                end else begin
                    chk("fifo_data", 32'(fifo_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic drive_byte(input logic [7:0] d, input logic last);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        @(negedge wr_clk);
        src_valid = 1'b1;
        src_data  = d;
        src_last  = last;
        while (!done) begin
            #1;
            if (src_ready) done = 1'b1;
            @(posedge wr_clk);
            if (!done) begin
                n++;
                if (n > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL handshake_timeout actual=stalled required=accept at %0t", $time);
                    return;
                end
                @(negedge wr_clk);
            end
        end
    endtask

    task automatic send_pkt(input logic [7:0] b[$]);
        model_pkt(b);
        for (int i = 0; i < b.size(); i++) drive_byte(b[i], i == b.size() - 1);
        @(negedge wr_clk);
        src_valid = 1'b0;
        src_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge wr_clk);
            n++;
        end
        repeat (3) @(negedge wr_clk);
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        chk("busy_after_drain", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge wr_clk);
        rst       = 1'b1;
        src_valid = 1'b0;
        src_last  = 1'b0;
        src_data  = 8'h00;
        fifo_full = 1'b0;
        #1;
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_ready", 32'(src_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(fifo_data), 32'd0);
        chk("rst_pkt_count", 32'(pkt_count), 32'd0);
        chk("rst_trunc", 32'(trunc_err), 32'd0);
        exp_q.delete();
        act_log.delete();
        m_seq      = 4'd0;
        m_pkts     = 0;
        m_trunc    = 0;
        trunc_seen = 0;
        @(negedge wr_clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] p[$];
        logic [7:0] lit[$];
        rst = 1'b1; src_valid = 1'b0; src_data = 8'h00; src_last = 1'b0; fifo_full = 1'b0;
        m_seq = 4'd0; m_pkts = 0; m_trunc = 0; trunc_seen = 0;

        // 1) basic 3-byte packet
        do_reset();
        p = '{8'h11, 8'h22, 8'h33};
        send_pkt(p);
        wait_drain();
        lit = '{8'hA0, 8'h11, 8'h22, 8'h33, 8'h03, 8'h00};
        for (int i = 0; i < lit.size(); i++) chk("t1_byte", 32'(act_log[i]), 32'(lit[i]));
        chk("t1_pkt_count", 32'(pkt_count), 32'd1);

        // 2) back-to-back 1-byte packets
        do_reset();
        p = '{8'h5A};
        send_pkt(p);
        p = '{8'hC3};
        send_pkt(p);
        wait_drain();
        lit = '{8'hA0, 8'h5A, 8'h01, 8'h5A, 8'hA1, 8'hC3, 8'h01, 8'hC3};
        for (int i = 0; i < lit.size(); i++) chk("t2_byte", 32'(act_log[i]), 32'(lit[i]));
        chk("t2_pkt_count", 32'(pkt_count), 32'(m_pkts));

        // 3) 20-byte packet cut at MAX_LEN, tail dropped, then a follow-up packet
        do_reset();
        p.delete();
        for (int i = 0; i < 20; i++) p.push_back(8'(i));
        send_pkt(p);
        p = '{8'h42};
        send_pkt(p);
        wait_drain();
        chk("t3_hdr", 32'(act_log[0]), 32'hA0);
        chk("t3_last_payload", 32'(act_log[16]), 32'h0F);
        chk("t3_cnt_trailer", 32'(act_log[17]), 32'h10);
        chk("t3_csum_trailer", 32'(act_log[18]), 32'h00);
        chk("t3_next_hdr", 32'(act_log[19]), 32'hA1);
        chk("t3_trunc_pulses", 32'(trunc_seen), 32'd1);
        chk("t3_trunc_model", 32'(trunc_seen), 32'(m_trunc));
        chk("t3_pkt_count", 32'(pkt_count), 32'd2);

        // 4) back-pressure mid-payload and during the count trailer
        do_reset();
        p = '{8'h11, 8'h22, 8'h33};
        fork
            send_pkt(p);
            begin
                int n;
                repeat (4) @(negedge wr_clk);
                fifo_full = 1'b1;
                repeat (5) @(negedge wr_clk);
                fifo_full = 1'b0;
                n = 0;
                while (act_log.size() < 4 && n < 100) begin
                    @(negedge wr_clk);
                    #3;
                    n++;
                end
                @(negedge wr_clk);
                fifo_full = 1'b1;
                repeat (5) @(negedge wr_clk);
                fifo_full = 1'b0;
            end
        join
        wait_drain();
        lit = '{8'hA0, 8'h11, 8'h22, 8'h33, 8'h03, 8'h00};
        chk("t4_len", 32'(act_log.size()), 32'd6);
        for (int i = 0; i < lit.size(); i++) chk("t4_byte", 32'(act_log[i]), 32'(lit[i]));

        // 5) reset mid-payload abandons the frame (seq is 1 here)
        exp_q.push_back({4'hA, m_seq});
        exp_q.push_back(8'hE1);
        exp_q.push_back(8'hE2);
        drive_byte(8'hE1, 1'b0);
        drive_byte(8'hE2, 1'b0);
        chk("t5_pre_pkt_count", 32'(pkt_count), 32'd1);
        do_reset();
        p = '{8'h77};
        send_pkt(p);
        wait_drain();
        chk("t5_hdr_after_rst", 32'(act_log[0]), 32'hA0);
        chk("t5_frame_len", 32'(act_log.size()), 32'd4);

        // 6) 17 packets: sequence nibble wraps
        do_reset();
        for (int k = 0; k < 17; k++) begin
            p = '{8'(k * 7 + 1)};
            send_pkt(p);
        end
        wait_drain();
        chk("t6_hdr2", 32'(act_log[4]), 32'hA1);
        chk("t6_hdr16", 32'(act_log[60]), 32'hAF);
        chk("t6_hdr17", 32'(act_log[64]), 32'hA0);
        chk("t6_pkt_count", 32'(pkt_count), 32'd17);
        chk("t6_pkt_model", 32'(pkt_count), 32'(m_pkts));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
